matrix_input_parser: RTL and testbench

//  UART receive-side parser for matrix entry. Consumes ASCII bytes from uart_rx:
//  "<rows> <cols> <e0> <e1> ... <e(rows*cols-1)>", decimal tokens separated by

---
 rtl/matrix_input_parser.sv | 211 +++++++++++++++++++++
 tb/tb_matrix_input_parser.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_parser.sv
// ASCII matrix-entry parser: turns "<rows> <cols> <e0> ..." decimal tokens from a
// UART byte stream into indexed element writes, closed by a commit or abort pulse.
module matrix_input_parser #(
  parameter int MAX_SIZE    = 5,
  parameter int ELEM_MAX    = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_req,
  output logic                  busy,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [2:0]            wr_row,
  output logic [2:0]            wr_col,
  output logic                  wr_en,
  output logic [4:0]            wr_idx,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_commit,
  output logic                  wr_abort,
  output logic                  err,
  output logic [1:0]            err_code
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int AW = DATA_WIDTH + 4;

  localparam logic [1:0] CODE_CHAR    = 2'd1;
  localparam logic [1:0] CODE_RANGE   = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ROW, S_GET_COL, S_GET_ELEM, S_COMMIT, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic                  start_d;
  logic [DATA_WIDTH-1:0] acc, acc_nx;
  logic                  have_digit, have_digit_nx;
  logic                  ovf, ovf_nx;
  logic [2:0]            rows, rows_nx, cols, cols_nx;
  logic [4:0]            idx, idx_nx;
  logic [1:0]            code, code_nx;
  logic [TW-1:0]         tmo, tmo_nx;

  logic [2:0]            wr_row_nx, wr_col_nx;
  logic                  wr_en_nx, wr_commit_nx, wr_abort_nx, err_nx;
  logic [4:0]            wr_idx_nx;
  logic [DATA_WIDTH-1:0] wr_data_nx;
  logic [1:0]            err_code_nx;

  logic                  is_digit, is_sep;
  logic [3:0]            digit;
  logic [AW-1:0]         acc_ext, limit;
  logic [5:0]            cells;

  assign busy     = (state != S_IDLE);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
  assign digit    = rx_data[3:0];
  assign acc_ext  = {4'b0, acc} * AW'(10) + AW'(digit);
  assign limit    = (state == S_GET_ELEM) ? AW'(ELEM_MAX) : AW'(MAX_SIZE);
  assign cells    = {3'b0, rows} * {3'b0, cols};

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nx      = state;
    acc_nx        = acc;
    have_digit_nx = have_digit;
    ovf_nx        = ovf;
    rows_nx       = rows;
    cols_nx       = cols;
    idx_nx        = idx;
    code_nx       = code;
    tmo_nx        = tmo;
    wr_row_nx     = wr_row;
    wr_col_nx     = wr_col;
    wr_idx_nx     = wr_idx;
    wr_data_nx    = wr_data;
    err_code_nx   = err_code;
    wr_en_nx      = 1'b0;
    wr_commit_nx  = 1'b0;
    wr_abort_nx   = 1'b0;
    err_nx        = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_req && !start_d) begin
          state_nx      = S_GET_ROW;
          err_code_nx   = 2'd0;
          idx_nx        = 5'd0;
          acc_nx        = '0;
          have_digit_nx = 1'b0;
          ovf_nx        = 1'b0;
          tmo_nx        = '0;
          wr_row_nx     = 3'd0;
          wr_col_nx     = 3'd0;
        end
      end

      S_GET_ROW, S_GET_COL, S_GET_ELEM: begin
        if (rx_valid) begin
          tmo_nx = '0;
          if (is_digit) begin
            have_digit_nx = 1'b1;
            if (!ovf) begin
              if (acc_ext > limit) ovf_nx = 1'b1;
              else                 acc_nx = acc_ext[DATA_WIDTH-1:0];
            end
          end else if (is_sep) begin
            if (have_digit) begin
              acc_nx        = '0;
              have_digit_nx = 1'b0;
              ovf_nx        = 1'b0;
              if (ovf || (state != S_GET_ELEM && acc == '0)) begin
                state_nx = S_ERROR;
                code_nx  = CODE_RANGE;
              end else if (state == S_GET_ROW) begin
                rows_nx  = acc[2:0];
                state_nx = S_GET_COL;
              end else if (state == S_GET_COL) begin
                cols_nx   = acc[2:0];
                wr_row_nx = rows;
                wr_col_nx = acc[2:0];
                state_nx  = S_GET_ELEM;
              end else begin
                wr_en_nx   = 1'b1;
                wr_idx_nx  = idx;
                wr_data_nx = acc;
                idx_nx     = idx + 5'd1;
                if ({1'b0, idx} == cells - 6'd1) state_nx = S_COMMIT;
              end
            end
          end else begin
            state_nx = S_ERROR;
            code_nx  = CODE_CHAR;
          end
        end else if (TIMEOUT_CYC != 0) begin
          tmo_nx = tmo + TW'(1);
          if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            state_nx = S_ERROR;
            code_nx  = CODE_TIMEOUT;
          end
        end
      end

      S_COMMIT: begin
        wr_commit_nx = 1'b1;
        state_nx     = S_IDLE;
      end

      S_ERROR: begin
        err_nx      = 1'b1;
        wr_abort_nx = 1'b1;
        err_code_nx = code;
        state_nx    = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      start_d    <= 1'b0;
      acc        <= '0;
      have_digit <= 1'b0;
      ovf        <= 1'b0;
      rows       <= 3'd0;
      cols       <= 3'd0;
      idx        <= 5'd0;
      code       <= 2'd0;
      tmo        <= '0;
      wr_row     <= 3'd0;
      wr_col     <= 3'd0;
      wr_en      <= 1'b0;
      wr_idx     <= 5'd0;
      wr_data    <= '0;
      wr_commit  <= 1'b0;
      wr_abort   <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state      <= state_nx;
      start_d    <= start_req;
      acc        <= acc_nx;
      have_digit <= have_digit_nx;
      ovf        <= ovf_nx;
      rows       <= rows_nx;
      cols       <= cols_nx;
      idx        <= idx_nx;
      code       <= code_nx;
      tmo        <= tmo_nx;
      wr_row     <= wr_row_nx;
      wr_col     <= wr_col_nx;
      wr_en      <= wr_en_nx;
      wr_idx     <= wr_idx_nx;
      wr_data    <= wr_data_nx;
      wr_commit  <= wr_commit_nx;
      wr_abort   <= wr_abort_nx;
      err        <= err_nx;
      err_code   <= err_code_nx;
    end
  end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Randomised scoreboard bench for matrix_input_parser: a token-level reference model
// predicts writes/commit/abort events; a negedge monitor compares what the DUT emits.
module tb_matrix_input_parser;
  localparam int MAX_SIZE = 5;
  localparam int ELEM_MAX = 9;
  localparam int DW       = 8;
  localparam int TO       = 100;

  logic          clk, rst, start_req, busy, rx_valid;
  logic [7:0]    rx_data;
  logic [2:0]    wr_row, wr_col;
  logic          wr_en, wr_commit, wr_abort, err;
  logic [4:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [1:0]    err_code;

  matrix_input_parser #(
    .MAX_SIZE(MAX_SIZE), .ELEM_MAX(ELEM_MAX), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .busy(busy),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_row(wr_row), .wr_col(wr_col), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_commit(wr_commit), .wr_abort(wr_abort),
    .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_WRITE = 0, EV_COMMIT = 1, EV_ABORT = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int idx;
    int data;
    int rows;
    int cols;
    int code;
  } ev_t;
  typedef byte unsigned bq_t[$];

  ev_t exp_q[$];
  bq_t stim;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_rx = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(ev_kind_t k, int i, int d, int r, int c, int code);
    ev_t e;
    e = '{kind: k, idx: i, data: d, rows: r, cols: c, code: code};
    exp_q.push_back(e);
  endfunction

  // Reference: tokens are whitespace-separated decimal numbers; first two are the
  // dimensions (1..MAX_SIZE), then rows*cols elements (0..ELEM_MAX).
  task automatic model(input bq_t s, output bit done);
    int  field = 0;
    int  val   = 0;
    bit  have  = 0;
    bit  big   = 0;
    int  rows  = 0;
    int  cols  = 0;
    int  lim;
    done = 0;
    foreach (s[i]) begin
      lim = (field < 2) ? MAX_SIZE : ELEM_MAX;
      if (s[i] >= 8'h30 && s[i] <= 8'h39) begin
        have = 1;
        val  = val * 10 + int'(s[i] - 8'h30);
        if (val > lim) big = 1;
      end else if (s[i] == 8'h20 || s[i] == 8'h0D || s[i] == 8'h0A) begin
        if (have) begin
          if (big || (field < 2 && val == 0)) begin
            push_ev(EV_ABORT, 0, 0, 0, 0, 2);
            done = 1;
            return;
          end
          if (field == 0) rows = val;
          else if (field == 1) cols = val;
          else begin
            push_ev(EV_WRITE, field - 2, val, rows, cols, 0);
            if (field - 2 == rows * cols - 1) begin
              push_ev(EV_COMMIT, 0, 0, 0, 0, 0);
              done = 1;
              return;
            end
          end
          field++;
          val  = 0;
          have = 0;
          big  = 0;
        end
      end else begin
        push_ev(EV_ABORT, 0, 0, 0, 0, 1);
        done = 1;
        return;
      end
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int      act_kind;
    ev_t     e;
    if (!rst) begin
      cyc++;
      if (rx_valid) last_rx = cyc;
      if (wr_en || wr_commit || wr_abort || err) begin
        act_kind = wr_en ? 0 : (wr_commit ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {29'd0, wr_en, wr_commit, wr_abort}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", act_kind, int'(e.kind));
          if (act_kind == int'(e.kind)) begin
            case (e.kind)
              EV_WRITE: begin
                check("wr_idx", int'(wr_idx), e.idx);
                check("wr_data", int'(wr_data), e.data);
                check("wr_row", int'(wr_row), e.rows);
                check("wr_col", int'(wr_col), e.cols);
              end
              EV_ABORT: begin
                check("err_with_abort", int'(err), int'(wr_abort));
                check("err_code", int'(err_code), e.code);
                if (e.code == 3)
                  check("timeout_gap", int'((cyc - last_rx) >= TO && (cyc - last_rx) <= TO + 3), 1);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic put_seps(input int n);
    byte unsigned sep_tab[3];
    sep_tab = '{8'h20, 8'h0D, 8'h0A};
    for (int i = 0; i < n; i++) stim.push_back(sep_tab[$urandom_range(0, 2)]);
  endtask

  task automatic start_parse();
    @(posedge clk); #1 start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("err_code_cleared", int'(err_code), 0);
  endtask

  task automatic send_stim(input bit poke);
    int n = 0;
    foreach (stim[i]) begin
      rx_valid = 1'b1;
      rx_data  = stim[i];
      if (poke && n == 2) start_req = 1'b1;
      @(posedge clk); #1;
      rx_valid  = 1'b0;
      start_req = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      n++;
    end
  endtask

  task automatic drain();
    int budget = TO + 300;
    while ((busy || exp_q.size() != 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_in_budget", int'(budget > 0), 1);
    if (budget == 0) exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic run_case(input bit poke);
    bit done;
    model(stim, done);
    if (!done) push_ev(EV_ABORT, 0, 0, 0, 0, 3);
    start_parse();
    send_stim(poke);
    drain();
    check("busy_low_after_case", int'(busy), 0);
    stim.delete();
  endtask

  task automatic gen_random();
    int r     = $urandom_range(1, MAX_SIZE);
    int c     = $urandom_range(1, MAX_SIZE);
    int fault = $urandom_range(0, 9);
    int bad   = $urandom_range(0, r * c - 1);
    int dims_bad[4];
    byte unsigned bad_chars[4];
    dims_bad  = '{0, 6, 7, 12};
    bad_chars = '{8'h78, 8'h2D, 8'h2C, 8'h09};
    put_seps($urandom_range(0, 2));
    if (fault == 1) put_str($sformatf("%0d", dims_bad[$urandom_range(0, 3)]));
    else            put_str($sformatf("%0d", r));
    put_seps($urandom_range(1, 2));
    put_str($sformatf("%0d", c));
    put_seps($urandom_range(1, 2));
    for (int i = 0; i < r * c; i++) begin
      if (fault == 3 && i == bad) stim.push_back(bad_chars[$urandom_range(0, 3)]);
      if ($urandom_range(0, 7) == 0) put_str("0");
      if (fault == 2 && i == bad) put_str($sformatf("%0d", $urandom_range(10, 99)));
      else                        put_str($sformatf("%0d", $urandom_range(0, ELEM_MAX)));
      if (!(fault == 4 && i == r * c - 1)) put_seps($urandom_range(1, 2));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=%0d expected=0", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs",
          int'({busy, wr_en, wr_commit, wr_abort, err, err_code, wr_row, wr_col, wr_idx}), 0);
    check("reset_wr_data", int'(wr_data), 0);

    put_str("2 3 1 2 3 4 5 6\n");    run_case(0);
    put_str("  1\r\n1 \n\n7 ");      run_case(0);
    put_str("6 2 1 1 ");             run_case(0);
    put_str("2 2 3 12 ");            run_case(0);
    put_str("0 1 5 ");               run_case(0);
    put_str("1 1 9 ");               run_case(0);
    put_str("1 1 10 ");              run_case(0);
    put_str("1 1 3 4");              run_case(0);
    put_str("1 2 4 5 ");             run_case(1);
    put_str("1 a");                  run_case(0);
    check("err_code_held", int'(err_code), 1);
    put_str("2 2 1 ");               run_case(0);

    // Reset in the middle of a parse: no commit or abort may follow.
    start_parse();
    put_str("3 3 ");
    send_stim(0);
    stim.delete();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("busy_after_mid_reset", int'(busy), 0);
    check("outputs_after_mid_reset", int'({wr_en, wr_commit, wr_abort, err, err_code}), 0);
    repeat (5) begin @(posedge clk); #1; end
    check("no_events_after_mid_reset", exp_q.size(), 0);

    put_str("1 1 0 ");               run_case(0);

    for (int k = 0; k < 40; k++) begin
      gen_random();
      run_case(k % 7 == 3);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
